instruction_fetch: RTL and testbench

- IF stage of the MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and the instruction memory, and drives the IF/ID register whose instruction word the decode stage splits into opcode, rs, rt, immediate and funct.
- The debug unit loads the program byte-by-byte through a load port. Execution advances only on i_step pulses, so continuous and step-by-step debug both work.

---
 rtl/if_pkg.sv | 15 +
 rtl/instruction_memory.sv | 31 +++
 rtl/instruction_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and state encoding for the MIPS instruction-fetch stage.
// No ports. Used by instruction_fetch.
package if_pkg;

  localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: DEPTH x NB words, one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports:
//   i_clk    - clock
//   i_we     - write enable
//   i_waddr  - word write address
//   i_wdata  - write data
//   i_raddr  - word read address
//   o_rdata  - read data (combinational)
module instruction_memory #(
  parameter int NB     = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [NB-1:0]     i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [NB-1:0]     o_rdata
);

  logic [NB-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the MIPS pipeline: owns the PC, the instruction memory and the
// IF/ID register. The debug unit loads the program byte-by-byte (big-endian
// within each word) while i_load_en is high; execution advances one
// instruction per i_step pulse.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_step                          - advance fetch by one instruction
//   i_load_en, i_load_valid, i_load_byte - program load port
//   o_instruction, o_pc_plus4, o_valid   - IF/ID register
//   o_pc                            - next fetch address
//   o_halt                          - HALT word fetched (sticky)
//   o_load_words, o_load_overflow   - load progress / overflow status
//   o_step_count                    - accepted steps (only with IF_STEP_COUNT_EN)
// Optional feature macro: IF_STEP_COUNT_EN
//
// state  | meaning
// RUN    | fetching on each i_step
// LOAD   | program bytes being written into memory
// HALTED | HALT fetched; outputs frozen until reset or load
module instruction_fetch
  import if_pkg::*;
#(
  parameter int NB        = 32,
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_load_en,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic [NB-1:0]     o_instruction,
  output logic [NB-1:0]     o_pc_plus4,
  output logic [NB-1:0]     o_pc,
  output logic              o_valid,
  output logic              o_halt,
  output logic [ADDR_W:0]   o_load_words,
  output logic              o_load_overflow
`ifdef IF_STEP_COUNT_EN
  ,
  output logic [NB-1:0]     o_step_count
`endif
);

  if_state_e         state_q, state_d;
  logic [NB-1:0]     pc_q, pc_d;
  logic [NB-1:0]     instr_q, instr_d;
  logic [NB-1:0]     pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;
  logic              halt_q, halt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              ovf_q, ovf_d;
  logic [23:0]       asm_q, asm_d;  // first three bytes of the word in flight
`ifdef IF_STEP_COUNT_EN
  logic [NB-1:0]     step_cnt_q, step_cnt_d;
`endif

  logic              load_entry;
  logic              step_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [NB-1:0]     rd_data;
  logic              fetch_halt;
  logic [ADDR_W-1:0] pc_word_nxt;

  assign load_entry  = i_load_en && (state_q != LOAD);
  // Load has priority: a step arriving while i_load_en is high is dropped.
  assign step_acc    = i_step && !i_load_en && (state_q == RUN);
  assign fetch_halt  = (rd_data == HALT_INSTR);
  assign pc_word_nxt = pc_q[ADDR_W+1:2] + ADDR_W'(1);
  assign mem_waddr   = load_entry ? '0 : word_cnt_q[ADDR_W-1:0];

  instruction_memory #(
    .NB     (NB),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (mem_waddr),
    .i_wdata ({asm_q, i_load_byte}),
    .i_raddr (pc_q[ADDR_W+1:2]),
    .o_rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
`ifdef IF_STEP_COUNT_EN
    step_cnt_d = step_cnt_q;
`endif

    case (state_q)
      RUN: begin
        if (i_load_en)                 state_d = LOAD;
        else if (i_step && fetch_halt) state_d = HALTED;
      end
      LOAD:    if (!i_load_en) state_d = RUN;
      HALTED:  if (i_load_en)  state_d = LOAD;
      default: state_d = RUN;
    endcase

    if (load_entry) begin
      pc_d       = '0;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      halt_d     = 1'b0;
      valid_d    = 1'b0;
      ovf_d      = 1'b0;
      instr_d    = NOP_INSTR;
`ifdef IF_STEP_COUNT_EN
      step_cnt_d = '0;
`endif
    end

    // Counters above already reflect the entry clear, so a byte arriving on
    // the entry cycle lands in word 0.
    if (i_load_en && i_load_valid) begin
      if (word_cnt_d == (ADDR_W+1)'(MEM_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        asm_d = {asm_q[15:0], i_load_byte};
        if (byte_cnt_d == 2'(BYTES_PER_WORD - 1)) begin
          mem_we     = 1'b1;
          word_cnt_d = word_cnt_d + (ADDR_W+1)'(1);
          byte_cnt_d = '0;
        end else begin
          byte_cnt_d = byte_cnt_d + 2'd1;
        end
      end
    end else if (!i_load_en) begin
      byte_cnt_d = '0;  // drop any partial word on leaving LOAD
    end

    if (step_acc) begin
      instr_d    = rd_data;
      pc_plus4_d = pc_q + NB'(4);
      valid_d    = 1'b1;
      if (fetch_halt) halt_d = 1'b1;
      else            pc_d   = {{(NB-ADDR_W-2){1'b0}}, pc_word_nxt, 2'b00};
`ifdef IF_STEP_COUNT_EN
      if (step_cnt_q != '1) step_cnt_d = step_cnt_q + NB'(1);
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= RUN;
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      asm_q      <= '0;
`ifdef IF_STEP_COUNT_EN
      step_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      asm_q      <= asm_d;
`ifdef IF_STEP_COUNT_EN
      step_cnt_q <= step_cnt_d;
`endif
    end
  end

  assign o_instruction   = instr_q;
  assign o_pc_plus4      = pc_plus4_q;
  assign o_pc            = pc_q;
  assign o_valid         = valid_q;
  assign o_halt          = halt_q;
  assign o_load_words    = word_cnt_q;
  assign o_load_overflow = ovf_q;
`ifdef IF_STEP_COUNT_EN
  assign o_step_count    = step_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int NB        = 32;
  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W    = 6;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_step = 1'b0;
  logic              i_load_en = 1'b0;
  logic              i_load_valid = 1'b0;
  logic [7:0]        i_load_byte = 8'h00;
  logic [NB-1:0]     o_instruction, o_pc_plus4, o_pc;
  logic              o_valid, o_halt, o_load_overflow;
  logic [ADDR_W:0]   o_load_words;
`ifdef IF_STEP_COUNT_EN
  logic [NB-1:0]     o_step_count;
`endif

  instruction_fetch #(.NB(NB), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_step          (i_step),
    .i_load_en       (i_load_en),
    .i_load_valid    (i_load_valid),
    .i_load_byte     (i_load_byte),
    .o_instruction   (o_instruction),
    .o_pc_plus4      (o_pc_plus4),
    .o_pc            (o_pc),
    .o_valid         (o_valid),
    .o_halt          (o_halt),
    .o_load_words    (o_load_words),
    .o_load_overflow (o_load_overflow)
`ifdef IF_STEP_COUNT_EN
    ,
    .o_step_count    (o_step_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model of memory, PC and halt status
  logic [31:0] model_mem [MEM_DEPTH];
  int          m_words;
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_steps;
  logic [31:0] exp_instr_q [$];
  logic [31:0] exp_pc4_q [$];
  logic [31:0] e_instr, e_pc4;

  task automatic load_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    @(negedge i_clk);
    i_load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) load_byte(w[31-8*i -: 8]);
    if (m_words < MEM_DEPTH) model_mem[m_words] = w;
    m_words++;
  endtask

  task automatic begin_load();
    @(negedge i_clk);
    i_load_en = 1'b1;
    m_pc = 0; m_halt = 0; m_words = 0; m_steps = 0;
    @(negedge i_clk);
  endtask

  task automatic end_load();
    @(negedge i_clk);
    i_load_en = 1'b0;
    @(negedge i_clk);
  endtask

  // Predict the fetch into the scoreboard, then pulse i_step.
  task automatic do_step();
    logic [31:0] w;
    w = model_mem[m_pc[7:2]];
    if (!m_halt) begin
      exp_instr_q.push_back(w);
      exp_pc4_q.push_back(m_pc + 32'd4);
      m_steps++;
      if (w == HALT) m_halt = 1;
      else           m_pc = (m_pc + 32'd4) & 32'h0000_00FF;
    end
    @(negedge i_clk);
    i_step = 1'b1;
    @(negedge i_clk);
    i_step = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'd0); end
    checks++; if (o_instruction !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected %h", o_instruction, 32'd0); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", o_halt); end
    checks++; if (o_load_words !== 7'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", o_load_words); end
    checks++; if (o_load_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", o_load_overflow); end
    i_reset = 1'b1;
    m_pc = 0; m_halt = 0; m_words = 0; m_steps = 0;
  endtask

  task automatic test_reset_mid_load();
    begin_load();
    load_word(32'hDEAD_BEEF);
    load_byte(8'h11);
    checks++; if (o_load_words !== 7'd1) begin errors++; $display("FAIL midload_words_pre: got %0d expected 1", o_load_words); end
    @(negedge i_clk);
    i_reset = 1'b0;
    i_load_en = 1'b0;
    #2;
    checks++; if (o_load_words !== 7'd0) begin errors++; $display("FAIL midload_words: got %0d expected 0", o_load_words); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midload_valid: got %b expected 0", o_valid); end
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL midload_pc: got %h expected 0", o_pc); end
    @(negedge i_clk);
    i_reset = 1'b1;
    m_pc = 0; m_halt = 0; m_steps = 0;
    begin_load();
    load_word(32'h2408_0005);
    end_load();
    do_step();
    e_instr = exp_instr_q.pop_front();
    e_pc4   = exp_pc4_q.pop_front();
    checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL reload_instr: got %h expected %h", o_instruction, e_instr); end
    checks++; if (o_pc_plus4 !== e_pc4) begin errors++; $display("FAIL reload_pc4: got %h expected %h", o_pc_plus4, e_pc4); end
  endtask

  task automatic test_program_halt();
    begin_load();
    load_word(32'h2001_000A);
    load_word(32'h2002_0014);
    load_word(32'h0022_1820);
    load_word(HALT);
    end_load();
    for (int s = 1; s <= 4; s++) begin
      do_step();
      e_instr = exp_instr_q.pop_front();
      e_pc4   = exp_pc4_q.pop_front();
      checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL prog_instr step%0d: got %h expected %h", s, o_instruction, e_instr); end
      checks++; if (o_pc_plus4 !== e_pc4) begin errors++; $display("FAIL prog_pc4 step%0d: got %h expected %h", s, o_pc_plus4, e_pc4); end
    end
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", o_halt); end
    checks++; if (o_pc !== 32'd12) begin errors++; $display("FAIL halt_pc: got %h expected %h", o_pc, 32'd12); end
    do_step();
    checks++; if (exp_instr_q.size() != 0) begin errors++; $display("FAIL halt_model_queue: got %0d entries expected 0", exp_instr_q.size()); end
    checks++; if (o_instruction !== HALT) begin errors++; $display("FAIL halt_hold_instr: got %h expected %h", o_instruction, HALT); end
    checks++; if (o_pc !== 32'd12) begin errors++; $display("FAIL halt_hold_pc: got %h expected %h", o_pc, 32'd12); end
    checks++; if (o_pc_plus4 !== 32'd16) begin errors++; $display("FAIL halt_hold_pc4: got %h expected %h", o_pc_plus4, 32'd16); end
`ifdef IF_STEP_COUNT_EN
    checks++; if (o_step_count !== m_steps) begin errors++; $display("FAIL halt_step_count: got %0d expected %0d", o_step_count, m_steps); end
`endif
  endtask

  task automatic test_load_step_priority();
    logic [31:0] w;
    w = 32'h8C43_0004;
    begin_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_load_valid = 1'b1;
      i_step       = 1'b1;
      i_load_byte  = w[31-8*i -: 8];
      @(negedge i_clk);
      i_load_valid = 1'b0;
      i_step       = 1'b0;
    end
    model_mem[0] = w;
    m_words = 1;
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL prio_pc: got %h expected 0", o_pc); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b expected 0", o_valid); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL prio_halt_cleared: got %b expected 0", o_halt); end
    checks++; if (o_load_words !== 7'(m_words)) begin errors++; $display("FAIL prio_words: got %0d expected %0d", o_load_words, m_words); end
`ifdef IF_STEP_COUNT_EN
    checks++; if (o_step_count !== 32'd0) begin errors++; $display("FAIL prio_step_count: got %0d expected 0", o_step_count); end
`endif
    end_load();
    do_step();
    e_instr = exp_instr_q.pop_front();
    e_pc4   = exp_pc4_q.pop_front();
    checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL prio_instr: got %h expected %h", o_instruction, e_instr); end
  endtask

  task automatic test_hold();
    repeat (10) @(negedge i_clk);
    checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL hold_instr: got %h expected %h", o_instruction, e_instr); end
    checks++; if (o_pc !== m_pc) begin errors++; $display("FAIL hold_pc: got %h expected %h", o_pc, m_pc); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", o_valid); end
  endtask

  task automatic test_overflow();
    begin_load();
    for (int i = 0; i < MEM_DEPTH; i++) load_word(32'h0100_0000 + 32'(i) * 32'h0001_0003);
    load_byte(8'hAA);
    checks++; if (o_load_words !== 7'd64) begin errors++; $display("FAIL ovf_words: got %0d expected 64", o_load_words); end
    checks++; if (o_load_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", o_load_overflow); end
    end_load();
  endtask

  task automatic test_wrap();
    for (int s = 0; s < MEM_DEPTH; s++) begin
      do_step();
      e_instr = exp_instr_q.pop_front();
      e_pc4   = exp_pc4_q.pop_front();
      checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL wrap_instr step%0d: got %h expected %h", s, o_instruction, e_instr); end
      checks++; if (o_pc_plus4 !== e_pc4) begin errors++; $display("FAIL wrap_pc4 step%0d: got %h expected %h", s, o_pc_plus4, e_pc4); end
    end
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", o_pc); end
    do_step();
    e_instr = exp_instr_q.pop_front();
    e_pc4   = exp_pc4_q.pop_front();
    checks++; if (o_instruction !== 32'h0100_0000) begin errors++; $display("FAIL wrap_mem0: got %h expected %h", o_instruction, 32'h0100_0000); end
    checks++; if (o_instruction !== e_instr) begin errors++; $display("FAIL wrap_last_instr: got %h expected %h", o_instruction, e_instr); end
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL wrap_pc_after: got %h expected 4", o_pc); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_program_halt();
    test_load_step_priority();
    test_hold();
    test_overflow();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
